// File: rtl/key_pkg.sv
// Shared definitions for the key sequence lock: FSM state encoding,
// default timing constants (50 MHz clock) and a small counter helper.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [7:0]  DEF_CODE        = 8'b00_01_10_11;
  localparam logic [27:0] DEF_TIMEOUT_CYC = 28'd250_000_000;  // 5 s
  localparam logic [27:0] DEF_OPEN_CYC    = 28'd150_000_000;  // 3 s
  localparam logic [31:0] DEF_LOCK_CYC    = 32'd1_500_000_000; // 30 s
  localparam logic [1:0]  DEF_MAX_FAIL    = 2'd3;

  // Increment a fail counter, saturating at max_val instead of wrapping.
  function automatic logic [1:0] sat_inc(input logic [1:0] val,
                                         input logic [1:0] max_val);
    logic [1:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_onehot_enc.sv
// Valid-press detector: a press is valid only when exactly one key bit is
// set; the position of that bit is returned as the key index.
module key_onehot_enc (
  input  logic [3:0] key_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  // Accept exactly one set bit and encode its position
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 2'd0;
    case (key_i)
      4'b0001: begin valid_o = 1'b1; idx_o = 2'd0; end
      4'b0010: begin valid_o = 1'b1; idx_o = 2'd1; end
      4'b0100: begin valid_o = 1'b1; idx_o = 2'd2; end
      4'b1000: begin valid_o = 1'b1; idx_o = 2'd3; end
      default: begin valid_o = 1'b0; idx_o = 2'd0; end
    endcase
  end

endmodule

// File: rtl/key_seq_lock.sv
// Four-digit keypad sequence lock. Collects digits from debounced key
// pulses, checks them against CODE, opens the door for a fixed time on a
// match and locks the keypad out after MAX_FAIL consecutive failures
// (wrong code or inter-press timeout). One shared up-counter times the
// entry gap, the door-open hold and the lockout.
module key_seq_lock
  import key_pkg::*;
#(
  parameter logic [7:0]  CODE        = DEF_CODE,
  parameter logic [27:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [27:0] OPEN_CYC    = DEF_OPEN_CYC,
  parameter logic [31:0] LOCK_CYC    = DEF_LOCK_CYC,
  parameter logic [1:0]  MAX_FAIL    = DEF_MAX_FAIL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_pulse,
  output logic       beep,
  output logic [2:0] digit_cnt,
  output logic       unlock,
  output logic       door_open,
  output logic       err,
  output logic       locked
);

  // Last counter value of each timed interval.
  localparam logic [31:0] TIMEOUT_LAST = {4'd0, TIMEOUT_CYC} - 32'd1;
  localparam logic [31:0] OPEN_LAST    = {4'd0, OPEN_CYC} - 32'd1;
  localparam logic [31:0] LOCK_LAST    = LOCK_CYC - 32'd1;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  digits_q, digits_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fail_q, fail_d;
  logic        beep_q, beep_d;
  logic        unlock_q, unlock_d;
  logic        err_q, err_d;
  logic        door_open_q, door_open_d;
  logic        locked_q, locked_d;

  logic        press_valid;
  logic [1:0]  press_idx;
  logic [1:0]  fail_next;

  key_onehot_enc u_enc (
    .key_i   (key_pulse),
    .valid_o (press_valid),
    .idx_o   (press_idx)
  );

  // Next-state and registered-output decode; a press beats a timeout
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 32'd1;
    digits_d    = digits_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    beep_d      = 1'b0;
    unlock_d    = 1'b0;
    err_d       = 1'b0;
    door_open_d = door_open_q;
    locked_d    = locked_q;
    fail_next   = sat_inc(fail_q, MAX_FAIL);
    case (state_q)
      ST_IDLE: begin
        timer_d = 32'd0;
        if (press_valid) begin
          digits_d = {digits_q[5:0], press_idx};
          cnt_d    = 3'd1;
          beep_d   = 1'b1;
          state_d  = ST_ENTRY;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (press_valid) begin
          digits_d = {digits_q[5:0], press_idx};
          cnt_d    = cnt_q + 3'd1;
          beep_d   = 1'b1;
          timer_d  = 32'd0;
          if (cnt_q == 3'd3) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_ENTRY;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          fail_d  = fail_next;
          cnt_d   = 3'd0;
          timer_d = 32'd0;
          if (fail_next == MAX_FAIL) begin
            state_d  = ST_LOCKOUT;
            locked_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        timer_d = 32'd0;
        cnt_d   = 3'd0;
        if (digits_q == CODE) begin
          unlock_d    = 1'b1;
          door_open_d = 1'b1;
          fail_d      = 2'd0;
          state_d     = ST_OPEN;
        end else begin
          err_d  = 1'b1;
          fail_d = fail_next;
          if (fail_next == MAX_FAIL) begin
            state_d  = ST_LOCKOUT;
            locked_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (timer_q == OPEN_LAST) begin
          door_open_d = 1'b0;
          timer_d     = 32'd0;
          state_d     = ST_IDLE;
        end else begin
          door_open_d = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          locked_d = 1'b0;
          fail_d   = 2'd0;
          timer_d  = 32'd0;
          state_d  = ST_IDLE;
        end else begin
          locked_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        timer_d     = 32'd0;
        cnt_d       = 3'd0;
        door_open_d = 1'b0;
        locked_d    = 1'b0;
      end
    endcase
  end

  // State, timer, digit store and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= 32'd0;
      digits_q    <= 8'd0;
      cnt_q       <= 3'd0;
      fail_q      <= 2'd0;
      beep_q      <= 1'b0;
      unlock_q    <= 1'b0;
      err_q       <= 1'b0;
      door_open_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      digits_q    <= digits_d;
      cnt_q       <= cnt_d;
      fail_q      <= fail_d;
      beep_q      <= beep_d;
      unlock_q    <= unlock_d;
      err_q       <= err_d;
      door_open_q <= door_open_d;
      locked_q    <= locked_d;
    end
  end

  assign beep      = beep_q;
  assign digit_cnt = cnt_q;
  assign unlock    = unlock_q;
  assign door_open = door_open_q;
  assign err       = err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_key_seq_lock.sv
// Self-checking bench for key_seq_lock: a fixed vector table, directed
// multi-cycle sequences and randomized presses, all compared against a
// queue/countdown reference model of the lock behaviour.
module tb_key_seq_lock;

  localparam logic [7:0]  P_CODE    = 8'b00_01_10_11;
  localparam logic [27:0] P_TIMEOUT = 28'd20;
  localparam logic [27:0] P_OPEN    = 28'd10;
  localparam logic [31:0] P_LOCK    = 32'd15;
  localparam logic [1:0]  P_MAXF    = 2'd3;
  localparam int T_TO   = 20;
  localparam int T_OPEN = 10;
  localparam int T_LOCK = 15;
  localparam int MAXF   = 3;

  logic       clk;
  logic       rst;
  logic [3:0] key_pulse;
  logic       beep, unlock, door_open, err, locked;
  logic [2:0] digit_cnt;

  key_seq_lock #(
    .CODE        (P_CODE),
    .TIMEOUT_CYC (P_TIMEOUT),
    .OPEN_CYC    (P_OPEN),
    .LOCK_CYC    (P_LOCK),
    .MAX_FAIL    (P_MAXF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .beep      (beep),
    .digit_cnt (digit_cnt),
    .unlock    (unlock),
    .door_open (door_open),
    .err       (err),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: digits entered so far, pending check, remaining
  // open/lock cycles, idle cycles since last press, consecutive failures.
  int m_q[$];
  bit m_check;
  int m_open, m_lock, m_gap, m_fails;
  bit e_beep, e_unlock, e_err, e_door, e_locked;
  int e_cnt;

  function automatic int code_digit(input int i);
    logic [7:0] c;
    c = P_CODE;
    return int'(c[7-2*i -: 2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_fail();
    e_err = 1'b1;
    if (m_fails < MAXF) m_fails++;
    if (m_fails == MAXF) m_lock = T_LOCK;
  endtask

  task automatic model_step(input logic [3:0] k, input logic r);
    bit match;
    e_beep = 1'b0; e_unlock = 1'b0; e_err = 1'b0;
    if (r) begin
      m_q.delete(); m_check = 1'b0; m_open = 0; m_lock = 0; m_gap = 0; m_fails = 0;
    end else if (m_check) begin
      m_check = 1'b0;
      match = 1'b1;
      for (int i = 0; i < 4; i++) if (m_q[i] != code_digit(i)) match = 1'b0;
      m_q.delete();
      if (match) begin
        e_unlock = 1'b1; m_open = T_OPEN; m_fails = 0;
      end else begin
        model_fail();
      end
    end else if (m_open > 0) begin
      m_open--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if ($countones(k) == 1) begin
      for (int i = 0; i < 4; i++) if (k[i]) m_q.push_back(i);
      e_beep = 1'b1;
      m_gap = 0;
      if (m_q.size() == 4) m_check = 1'b1;
    end else if (m_q.size() > 0) begin
      m_gap++;
      if (m_gap == T_TO) begin
        m_q.delete(); m_gap = 0;
        model_fail();
      end
    end
    e_door   = (m_open > 0);
    e_locked = (m_lock > 0);
    e_cnt    = m_q.size();
  endtask

  // One clock: drive on the falling edge, step the model at the rising
  // edge, compare all outputs just after it.
  task automatic cycle(input logic [3:0] k, input logic r);
    @(negedge clk);
    key_pulse = k;
    rst = r;
    @(posedge clk);
    model_step(k, r);
    #1;
    chk("m_beep",   32'(beep),      32'(e_beep));
    chk("m_unlock", 32'(unlock),    32'(e_unlock));
    chk("m_err",    32'(err),       32'(e_err));
    chk("m_door",   32'(door_open), 32'(e_door));
    chk("m_locked", 32'(locked),    32'(e_locked));
    chk("m_cnt",    32'(digit_cnt), 32'(e_cnt));
  endtask

  task automatic enter_code(input logic [7:0] c, output int nbeep);
    logic [3:0] one;
    logic [1:0] d;
    one = 4'b0001;
    nbeep = 0;
    for (int i = 0; i < 4; i++) begin
      d = c[7-2*i -: 2];
      cycle(one << d, 1'b0);
      if (beep) nbeep++;
    end
  endtask

  typedef struct {
    logic [3:0] key;
    logic       r;
    logic       beep, unlock, err, door, locked;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] k, input logic r, input logic b, input logic u,
                     input logic e, input logic d, input logic l, input logic [2:0] c);
    vec_t v;
    v.key = k; v.r = r; v.beep = b; v.unlock = u; v.err = e;
    v.door = d; v.locked = l; v.cnt = c;
    tbl.push_back(v);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, n, at, cnt_at, sel;
    logic [3:0] k;
    logic [3:0] one;
    logic r;
    one = 4'b0001;
    rst = 1'b1;
    key_pulse = 4'b0000;

    //       key     rst   beep  unl   err   door  lock  cnt
    add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    add(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    add(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    add(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    add(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    add(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    add(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    add(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    add(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
    add(4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].key, tbl[i].r);
      chk($sformatf("tbl%0d_beep", i),   32'(beep),      32'(tbl[i].beep));
      chk($sformatf("tbl%0d_unlock", i), 32'(unlock),    32'(tbl[i].unlock));
      chk($sformatf("tbl%0d_err", i),    32'(err),       32'(tbl[i].err));
      chk($sformatf("tbl%0d_door", i),   32'(door_open), 32'(tbl[i].door));
      chk($sformatf("tbl%0d_locked", i), 32'(locked),    32'(tbl[i].locked));
      chk($sformatf("tbl%0d_cnt", i),    32'(digit_cnt), 32'(tbl[i].cnt));
    end

    // Correct code: four beeps, unlock two cycles after the 4th press, door hold length
    cycle(4'b0000, 1'b1);
    enter_code(P_CODE, nb);
    chk("code_beeps", 32'(nb), 32'd4);
    chk("unlock_early", 32'(unlock), 32'd0);
    cycle(4'b0000, 1'b0);
    chk("unlock_lat", 32'(unlock), 32'd1);
    n = door_open ? 1 : 0;
    for (int j = 0; j < T_OPEN + 4; j++) begin
      cycle(4'b0000, 1'b0);
      if (door_open) n++;
    end
    chk("door_len", 32'(n), 32'(T_OPEN));

    // Wrong code 3,3,3,3: err, count cleared, back in IDLE
    enter_code(8'hFF, nb);
    cycle(4'b0000, 1'b0);
    chk("wrong_err", 32'(err), 32'd1);
    chk("wrong_unlock", 32'(unlock), 32'd0);
    chk("wrong_cnt", 32'(digit_cnt), 32'd0);
    cycle(4'b0001, 1'b0);
    chk("wrong_idle_press", 32'(beep), 32'd1);

    // Three consecutive wrong codes: lockout of LOCK_CYC, presses ignored
    cycle(4'b0000, 1'b1);
    for (int w = 0; w < 3; w++) begin
      enter_code(8'hFF, nb);
      cycle(4'b0000, 1'b0);
    end
    chk("lock_on", 32'(locked), 32'd1);
    n = locked ? 1 : 0;
    for (int j = 0; j < T_LOCK + 4; j++) begin
      k = (j == 0) ? 4'b0010 : 4'b0000;
      cycle(k, 1'b0);
      if (j == 0) chk("lock_press_beep", 32'(beep), 32'd0);
      if (locked) n++;
    end
    chk("lock_len", 32'(n), 32'(T_LOCK));
    cycle(4'b0001, 1'b0);
    chk("after_lock_press", 32'(beep), 32'd1);
    chk("after_lock_cnt", 32'(digit_cnt), 32'd1);

    // Timeout after one press
    cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b0);
    at = 0;
    cnt_at = 7;
    for (int j = 1; j <= T_TO + 3; j++) begin
      cycle(4'b0000, 1'b0);
      if (err && at == 0) begin
        at = j;
        cnt_at = int'(digit_cnt);
      end
    end
    chk("timeout_at", 32'(at), 32'(T_TO));
    chk("timeout_cnt", 32'(cnt_at), 32'd0);

    // Press in the exact timeout cycle wins
    cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b0);
    for (int j = 0; j < T_TO - 1; j++) cycle(4'b0000, 1'b0);
    cycle(4'b0010, 1'b0);
    chk("edge_press_beep", 32'(beep), 32'd1);
    chk("edge_press_err", 32'(err), 32'd0);
    chk("edge_press_cnt", 32'(digit_cnt), 32'd2);
    cycle(4'b0000, 1'b0);
    chk("edge_press_noerr", 32'(err), 32'd0);

    // Reset mid-entry and mid-open
    cycle(4'b0000, 1'b1);
    cycle(4'b0001, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b1);
    chk("rst_entry_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_entry_beep", 32'(beep), 32'd0);
    enter_code(P_CODE, nb);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    chk("pre_rst_door", 32'(door_open), 32'd1);
    cycle(4'b0000, 1'b1);
    chk("rst_open_door", 32'(door_open), 32'd0);
    chk("rst_open_unlock", 32'(unlock), 32'd0);
    chk("rst_open_locked", 32'(locked), 32'd0);
    cycle(4'b0001, 1'b0);
    chk("rst_open_idle", 32'(beep), 32'd1);

    // Randomized presses against the reference model
    cycle(4'b0000, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      sel = int'($urandom_range(0, 99));
      r = 1'b0;
      k = 4'b0000;
      if (sel < 1) r = 1'b1;
      else if (sel < 30) k = one << code_digit(m_q.size() % 4);
      else if (sel < 45) k = one << $urandom_range(0, 3);
      else if (sel < 50) k = 4'($urandom);
      else k = 4'b0000;
      cycle(k, r);
      if (i % 300 == 150) begin
        for (int j = 0; j < T_TO + 2; j++) cycle(4'b0000, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
